mem_ack_ram: RTL and testbench
==============================

// Module: mem_ack_ram
// PURPOSE
//  Word-addressed backing RAM with programmable access latency, directly downstream of the cache
//  management unit. Serves the CMU's single-word cs/we/addr -> ack handshake for write-back and
//  refill bursts, one word per request. Lets the cache be exercised against realistic slow memory.
// PARAMETERS
//  ADDR_WIDTH  10  word-address bits; depth = 2**ADDR_WIDTH 32-bit words
//  LATENCY     4   cycles from request acceptance to ack; legal range 1..15
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    asynchronous, active-high reset
//  cs_i       in   1    request valid; driven by CMU mem_cs_o
//  we_i       in   1    1 = write, 0 = read; driven by CMU mem_we_o
//  addr_i     in   32   byte address; word index = addr_i[ADDR_WIDTH+1:2]
//  data_i     in   32   write data; driven by CMU mem_data_o
//  data_o     out  32   read data, valid only in the ack_o cycle; feeds CMU mem_data_i
//  ack_o      out  1    one-cycle completion pulse; feeds CMU mem_ack_i
//  mem_state  out  2    debug: current FSM state encoding
// BEHAVIOUR
//  - Reset values: ack_o=0, data_o=0, mem_state=S_IDLE, latency counter=0.
//  - Reset does not clear the RAM array. Array contents are undefined until written.
//  - FSM states: S_IDLE=0, S_BUSY=1, S_ACK=2. Encoding 3 is illegal; return to S_IDLE.
//  - S_IDLE, cs_i=1 at an edge: request accepted.
//    - Latch word index, we_i and data_i into request registers.
//    - Load counter with LATENCY-1.
//    - Go to S_BUSY, or directly to S_ACK when LATENCY=1.
//  - S_BUSY: decrement counter each cycle. When counter reaches 1, next state is S_ACK.
//    - Latency rule: request accepted at edge T gives ack_o high during cycle T+LATENCY.
//  - S_ACK: ack_o=1 for exactly one cycle.
//    - Read: data_o = RAM[latched index].
//    - Write: RAM[latched index] <= latched data at the edge ending the S_ACK cycle.
//    - Next state is always S_IDLE. No request is accepted in the S_ACK cycle.
//  - Back-to-back: if cs_i is still high in the cycle after S_ACK, accept the new address.
//    - This is the CMU's burst pattern: word_count advances on ack.
//    - Throughput: one word per LATENCY+1 cycles.
//  - Abort: cs_i=0 while in S_BUSY.
//    - Go to S_IDLE next edge. No ack is issued and no write is performed.
//  - Request fields (addr_i, we_i, data_i) changing while in S_BUSY are ignored; latched values rule.
//  - Address upper bits above ADDR_WIDTH+1 and addr_i[1:0] are ignored, so addresses alias.
//  - Outside S_ACK: ack_o=0 and data_o=0.
//  - Reset asserted mid-request: immediate return to S_IDLE, ack_o=0, pending write discarded.
//    Words already written are preserved.
//  - mem_state = state register, for waveform debug.
// TESTING (LATENCY=4 unless noted)
//  1. Single write then read.
//     - Stimulus: write 0xDEADBEEF to addr 0x40, then read addr 0x40.
//     - Required: each ack is exactly 4 cycles after acceptance; the read returns 0xDEADBEEF.
//  2. CMU-style refill burst.
//     - Stimulus: preload 0x100..0x10C with 1..4; cs held high; addr steps by 4 on each ack.
//     - Required: 4 acks spaced 5 cycles apart, data 1,2,3,4 in order.
//  3. Abort.
//     - Stimulus: write 0x55 to 0x20; drop cs_i 2 cycles after acceptance.
//     - Required: no ack, and a later read of 0x20 returns its old value.
//  4. Latched fields.
//     - Stimulus: change addr_i/data_i during S_BUSY.
//     - Required: the write lands at the originally latched address with the originally latched data.
//  5. Reset mid-request.
//     - Stimulus: assert rst while in S_BUSY.
//     - Required: ack_o=0 and mem_state=0 immediately; the next request completes normally.
//  6. LATENCY=1, aliasing.
//     - Stimulus: read of 0x1000 with ADDR_WIDTH=10.
//     - Required: ack in the cycle after acceptance; returns word 0.

Source files
------------

// File: rtl/mem_ack_ram.sv
`default_nettype none
// ============================================================================
// Module      : mem_ack_ram
// Description : Word-addressed backing RAM with programmable request-to-ack
//               latency, serving a single-word cs/we/addr -> ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ack_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic [1:0]  mem_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [3:0] C_LOAD = 4'(LATENCY - 1);
    localparam int         C_DEPTH = 2 ** ADDR_WIDTH;

    logic [1:0]            r_state;
    logic [1:0]            w_next;
    logic [3:0]            r_count;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [ADDR_WIDTH-1:0] w_idx_in;
    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic                  r_we;
    logic                  w_rd_we;
    logic                  w_rd_en;
    logic                  w_wr_en;
    logic                  w_accept;
    logic [31:0]           r_data;
    logic [31:0]           r_rdata;
    logic [31:0]           r_mem [C_DEPTH];
    logic                  w_unused;

    assign w_idx_in = addr_i[ADDR_WIDTH+1:2];
    assign w_unused = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};
    assign w_accept = (r_state == S_IDLE) && cs_i;

    // State register and latency counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= 4'd0;
        end else begin
            r_state <= w_next;
            if (w_accept)
                r_count <= C_LOAD;
            else if (r_state == S_BUSY)
                r_count <= r_count - 4'd1;
        end
    end

    // Request fields are frozen at acceptance; later changes on the bus are ignored
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx  <= w_idx_in;
            r_we   <= we_i;
            r_data <= data_i;
        end
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = cs_i ? ((LATENCY == 1) ? S_ACK : S_BUSY) : S_IDLE;
            S_BUSY: begin
                if (!cs_i)
                    w_next = S_IDLE;
                else if (r_count == 4'd1)
                    w_next = S_ACK;
                else
                    w_next = S_BUSY;
            end
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The read is issued on the edge entering S_ACK; with LATENCY=1 that edge is
    // the acceptance edge itself, so the index comes straight from the bus.
    assign w_rd_idx = (r_state == S_IDLE) ? w_idx_in : r_idx;
    assign w_rd_we  = (r_state == S_IDLE) ? we_i : r_we;
    assign w_rd_en  = (w_next == S_ACK) && !w_rd_we;
    assign w_wr_en  = (r_state == S_ACK) && r_we;

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_idx] <= r_data;
        if (w_rd_en)
            r_rdata <= r_mem[w_rd_idx];
    end

    always_comb begin
        ack_o  = 1'b0;
        data_o = 32'd0;
        if (r_state == S_ACK) begin
            ack_o = 1'b1;
            if (!r_we)
                data_o = r_rdata;
        end
    end

    assign mem_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mem_ack_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ack_ram
// Description : Directed scoreboard bench for mem_ack_ram (LATENCY 4 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ack_ram;

    localparam int AW  = 10;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs, we, cs1, we1;
    logic [31:0] addr, wdata, rdata, addr1, wdata1, rdata1;
    logic        ack, ack1;
    logic [1:0]  st, st1;

    always #5 clk = ~clk;

    mem_ack_ram #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .cs_i(cs), .we_i(we), .addr_i(addr), .data_i(wdata),
        .data_o(rdata), .ack_o(ack), .mem_state(st)
    );

    mem_ack_ram #(.ADDR_WIDTH(AW), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .cs_i(cs1), .we_i(we1), .addr_i(addr1), .data_i(wdata1),
        .data_o(rdata1), .ack_o(ack1), .mem_state(st1)
    );

    typedef struct {
        int          when;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    exp_t        sbq1[$];
    exp_t        e0, e1;
    logic [31:0] model [int];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'(2 ** AW - 1));
    endfunction

    // Scoreboard monitors: every ack pops one expectation and checks timing and data
    always @(negedge clk) begin
        if (!rst) begin
            if (ack) begin
                chk("ack_pending", 32'(sbq.size() > 0), 32'd1);
                if (sbq.size() > 0) begin
                    e0 = sbq.pop_front();
                    chk("ack_cycle", 32'(cyc), 32'(e0.when));
                    chk("rdata", rdata, e0.data);
                end
            end else begin
                chk("idle_data_zero", rdata, 32'd0);
                if (sbq.size() > 0 && sbq[0].when < cyc) begin
                    chk("missing_ack", 32'(cyc), 32'(sbq[0].when));
                    void'(sbq.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ack1) begin
                chk("ack1_pending", 32'(sbq1.size() > 0), 32'd1);
                if (sbq1.size() > 0) begin
                    e1 = sbq1.pop_front();
                    chk("ack1_cycle", 32'(cyc), 32'(e1.when));
                    chk("rdata1", rdata1, e1.data);
                end
            end else if (sbq1.size() > 0 && sbq1[0].when < cyc) begin
                chk("missing_ack1", 32'(cyc), 32'(sbq1[0].when));
                void'(sbq1.pop_front());
            end
        end
    end

    task automatic wait_ack();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 40);
        if (!ack) chk("ack_timeout", 32'(n), 32'd0);
    endtask

    task automatic wait_ack1();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack1 && n < 40);
        if (!ack1) chk("ack1_timeout", 32'(n), 32'd0);
    endtask

    // One request on the LATENCY=4 instance, started from idle
    task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; we = w; addr = a; wdata = d;
        sbq.push_back('{cyc + LAT, w ? 32'd0 : model[widx(a)]});
        if (w) model[widx(a)] = d;
        wait_ack();
        cs = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cs = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        cs1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", 32'(st), 32'd0);
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_data", rdata, 32'd0);
        chk("reset_state1", 32'(st1), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single write then read
        req(1'b1, 32'h40, 32'hDEADBEEF);
        req(1'b0, 32'h40, 32'h0);

        // Refill burst with cs held high, address stepped on each ack
        for (int k = 0; k < 4; k++) req(1'b1, 32'h100 + 32'(4 * k), 32'(k + 1));
        @(negedge clk);
        cs = 1'b1; we = 1'b0; addr = 32'h100;
        sbq.push_back('{cyc + LAT, 32'd1});
        for (int k = 1; k <= 4; k++) begin
            wait_ack();
            if (k < 4) begin
                addr = 32'h100 + 32'(4 * k);
                sbq.push_back('{cyc + 1 + LAT, 32'(k + 1)});
            end
        end
        cs = 1'b0;

        // Abort: cs dropped two cycles after acceptance
        req(1'b1, 32'h20, 32'h11);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h55;
        repeat (2) @(negedge clk);
        cs = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_idle", 32'(st), 32'd0);
        req(1'b0, 32'h20, 32'h0);

        // Request fields change during S_BUSY
        req(1'b1, 32'h84, 32'h1234);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = 32'h80; wdata = 32'hA5A5A5A5;
        sbq.push_back('{cyc + LAT, 32'd0});
        model[widx(32'h80)] = 32'hA5A5A5A5;
        @(negedge clk);
        addr = 32'h84; wdata = 32'hFFFFFFFF; we = 1'b0;
        wait_ack();
        cs = 1'b0;
        req(1'b0, 32'h80, 32'h0);
        req(1'b0, 32'h84, 32'h0);

        // Reset asserted while busy
        req(1'b1, 32'h200, 32'h66);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = 32'h200; wdata = 32'h77;
        repeat (2) @(negedge clk);
        chk("busy_before_reset", 32'(st), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_state", 32'(st), 32'd0);
        cs = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        req(1'b0, 32'h200, 32'h0);
        req(1'b0, 32'h40, 32'h0);

        // LATENCY=1 instance: write word 0, then read through aliased address
        @(negedge clk);
        cs1 = 1'b1; we1 = 1'b1; addr1 = 32'h0; wdata1 = 32'hCAFEF00D;
        sbq1.push_back('{cyc + 1, 32'd0});
        wait_ack1();
        cs1 = 1'b0;
        @(negedge clk);
        cs1 = 1'b1; we1 = 1'b0; addr1 = 32'h1000;
        sbq1.push_back('{cyc + 1, 32'hCAFEF00D});
        wait_ack1();
        cs1 = 1'b0;

        repeat (10) @(negedge clk);
        chk("sbq_drained", 32'(sbq.size() + sbq1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
